// File: rtl/l2_arb_pkg.sv
// Shared types for the L2 request-port arbiter: FSM states and requester identifiers.
package l2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    // Encoding matches the bit position of each requester in the picker vectors.
    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone request wins outright; on contention the side
// that was not granted last time wins.
module rr_arb2
    import l2_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (last == REQ_I) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/l2_arbiter.sv
// Shares the L2 request port between the I-cache and D-cache miss paths. One requester
// is served at a time, and a one-cycle release gap follows every L2 response.
module l2_arbiter
    import l2_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_address,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic              l2_resp,
    input  logic [LINE_W-1:0] l2_rdata
);

    arb_state_t        state_q, state_d;
    req_id_t           last_q, last_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [1:0]        req;
    logic [1:0]        grant;
    logic              serving;

    assign req     = {d_read | d_write, i_read};
    assign serving = (state_q == SERVE_I) || (state_q == SERVE_D);

    rr_arb2 u_rr_arb2 (
        .req   (req),
        .last  (last_q),
        .grant (grant)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (grant[REQ_D]) begin
                    // Write-back wins if the D-cache illegally raises both ops.
                    state_d = SERVE_D;
                    last_d  = REQ_D;
                    write_d = d_write;
                    addr_d  = d_address;
                    wdata_d = d_write ? d_wdata : '0;
                end else if (grant[REQ_I]) begin
                    state_d = SERVE_I;
                    last_d  = REQ_I;
                    write_d = 1'b0;
                    addr_d  = i_address;
                    wdata_d = '0;
                end
            end
            SERVE_I, SERVE_D: begin
                if (l2_resp) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= REQ_I;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // L2 command comes only from the latches, so it is stable for the whole service.
    always_comb begin
        l2_read    = serving & ~write_q;
        l2_write   = serving & write_q;
        l2_address = serving ? addr_q : '0;
        l2_wdata   = serving ? wdata_q : '0;
        i_resp     = (state_q == SERVE_I) & l2_resp;
        d_resp     = (state_q == SERVE_D) & l2_resp;
        i_rdata    = i_resp ? l2_rdata : '0;
        d_rdata    = d_resp ? l2_rdata : '0;
    end

    a_d_read_write_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(d_read && d_write));
    a_resp_only_serving: assert property (@(posedge clk) disable iff (!rst_n)
        l2_resp |-> serving);
    a_one_l2_cmd: assert property (@(posedge clk) disable iff (!rst_n)
        !(l2_read && l2_write));
    a_one_resp: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_resp && d_resp));

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed and randomized checks of l2_arbiter with a scoreboard of outstanding requests.
module tb_l2_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned LW = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_read = 1'b0;
    logic [AW-1:0] i_address = '0;
    logic          i_resp;
    logic [LW-1:0] i_rdata;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [AW-1:0] d_address = '0;
    logic [LW-1:0] d_wdata = '0;
    logic          d_resp;
    logic [LW-1:0] d_rdata;
    logic          l2_read;
    logic          l2_write;
    logic [AW-1:0] l2_address;
    logic [LW-1:0] l2_wdata;
    logic          l2_resp = 1'b0;
    logic [LW-1:0] l2_rdata = '0;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] i_q[$];
    logic [AW-1:0] d_q[$];
    logic [LW-1:0] dw_q[$];
    logic          dwr_q[$];

    l2_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_read     (i_read),
        .i_address  (i_address),
        .i_resp     (i_resp),
        .i_rdata    (i_rdata),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_address  (d_address),
        .d_wdata    (d_wdata),
        .d_resp     (d_resp),
        .d_rdata    (d_rdata),
        .l2_read    (l2_read),
        .l2_write   (l2_write),
        .l2_address (l2_address),
        .l2_wdata   (l2_wdata),
        .l2_resp    (l2_resp),
        .l2_rdata   (l2_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Line the L2 model returns for a given address.
    function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
        return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'h1234_5678, {a[15:0], a[31:16]},
                a ^ 32'hFFFF_0000, a - 32'd1, 32'hC0DE_0000 | {16'h0, a[15:0]}};
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        i_read  = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
        l2_resp = 1'b0;
        l2_rdata = '0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        logic          is_d;
        logic          i_got;
        logic          d_got;
        logic          busy;
        logic          wr;
        int            cnt;
        int            w;
        logic [AW-1:0] cur_addr;
        logic [AW-1:0] exp_a;
        logic [AW-1:0] tmp;

        // Reset state and a single I-cache read.
        do_reset();
        #1;
        chk_b("rst_l2_read", l2_read, 1'b0);
        chk_b("rst_l2_write", l2_write, 1'b0);
        chk_b("rst_i_resp", i_resp, 1'b0);
        chk_b("rst_d_resp", d_resp, 1'b0);
        chk_a("rst_l2_address", l2_address, 32'h0);
        i_read = 1'b1;
        i_address = 32'h0000_1000;
        cyc();
        chk_b("t1_l2_read", l2_read, 1'b1);
        chk_b("t1_l2_write", l2_write, 1'b0);
        chk_a("t1_l2_address", l2_address, 32'h0000_1000);
        l2_resp = 1'b1;
        l2_rdata = line_of(32'h0000_1000);
        #1;
        chk_b("t1_i_resp", i_resp, 1'b1);
        chk_w("t1_i_rdata", i_rdata, line_of(32'h0000_1000));
        chk_b("t1_d_resp", d_resp, 1'b0);
        cyc();
        i_read = 1'b0;
        l2_resp = 1'b0;
        l2_rdata = line_of(32'hDEAD_BEEF);
        #1;
        chk_b("t1_i_resp_low", i_resp, 1'b0);
        chk_w("t1_i_rdata_zero", i_rdata, '0);
        chk_b("t1_release_read", l2_read, 1'b0);

        // Simultaneous requests: D first, then I after the release gap.
        do_reset();
        i_read = 1'b1;
        i_address = 32'h0000_2000;
        d_read = 1'b1;
        d_address = 32'h0000_3000;
        cyc();
        chk_b("t2_d_read", l2_read, 1'b1);
        chk_a("t2_d_addr", l2_address, 32'h0000_3000);
        l2_resp = 1'b1;
        l2_rdata = line_of(32'h0000_3000);
        #1;
        chk_b("t2_d_resp", d_resp, 1'b1);
        chk_b("t2_i_resp", i_resp, 1'b0);
        chk_w("t2_d_rdata", d_rdata, line_of(32'h0000_3000));
        cyc();
        d_read = 1'b0;
        l2_resp = 1'b0;
        #1;
        chk_b("t2_gap_release", l2_read, 1'b0);
        cyc();
        chk_b("t2_gap_idle", l2_read, 1'b0);
        cyc();
        chk_b("t2_i_read", l2_read, 1'b1);
        chk_a("t2_i_addr", l2_address, 32'h0000_2000);
        l2_resp = 1'b1;
        l2_rdata = line_of(32'h0000_2000);
        #1;
        chk_b("t2_i_resp2", i_resp, 1'b1);
        chk_w("t2_i_rdata", i_rdata, line_of(32'h0000_2000));
        cyc();
        i_read = 1'b0;
        l2_resp = 1'b0;

        // Sustained contention: grants alternate D, I, D, I, D, I.
        do_reset();
        i_read = 1'b1;
        i_address = 32'h0000_5000;
        d_write = 1'b1;
        d_address = 32'h0000_6000;
        d_wdata = rand_line();
        for (int k = 0; k < 6; k++) begin
            w = 0;
            while (!(l2_read || l2_write) && w < 10) begin
                cyc();
                w++;
            end
            chk_b("t3_cmd_seen", l2_read | l2_write, 1'b1);
            is_d = (k % 2 == 0);
            exp_a = is_d ? d_address : i_address;
            chk_b("t3_write", l2_write, is_d);
            chk_b("t3_read", l2_read, !is_d);
            chk_a("t3_addr", l2_address, exp_a);
            if (is_d) chk_w("t3_wdata", l2_wdata, d_wdata);
            l2_resp = 1'b1;
            l2_rdata = line_of(exp_a);
            #1;
            chk_b("t3_d_resp", d_resp, is_d);
            chk_b("t3_i_resp", i_resp, !is_d);
            cyc();
            l2_resp = 1'b0;
            if (is_d) begin
                d_address = d_address + 32'h40;
                d_wdata = rand_line();
            end else begin
                i_address = i_address + 32'h40;
            end
        end
        i_read = 1'b0;
        d_write = 1'b0;

        // D drops its request mid-service; the transaction still completes.
        do_reset();
        d_read = 1'b1;
        d_address = 32'h0000_8000;
        cyc();
        chk_b("t4_read", l2_read, 1'b1);
        d_read = 1'b0;
        d_address = 32'h0000_9999;
        repeat (3) cyc();
        chk_b("t4_hold_read", l2_read, 1'b1);
        chk_a("t4_hold_addr", l2_address, 32'h0000_8000);
        l2_resp = 1'b1;
        l2_rdata = line_of(32'h0000_8000);
        #1;
        chk_b("t4_d_resp", d_resp, 1'b1);
        chk_w("t4_d_rdata", d_rdata, line_of(32'h0000_8000));
        cyc();
        l2_resp = 1'b0;
        #1;
        chk_b("t4_d_resp_once", d_resp, 1'b0);
        chk_b("t4_release", l2_read, 1'b0);
        cyc();
        cyc();
        chk_b("t4_no_regrant", l2_read | l2_write, 1'b0);

        // Reset while serving I: outputs clear and last_grant returns to I.
        do_reset();
        i_read = 1'b1;
        i_address = 32'h0000_A000;
        cyc();
        chk_b("t5_serve", l2_read, 1'b1);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        d_read = 1'b1;
        d_address = 32'h0000_B000;
        #1;
        chk_b("t5_rst_read", l2_read, 1'b0);
        chk_b("t5_rst_write", l2_write, 1'b0);
        chk_a("t5_rst_addr", l2_address, 32'h0);
        chk_b("t5_rst_i_resp", i_resp, 1'b0);
        cyc();
        chk_b("t5_d_first", l2_read, 1'b1);
        chk_a("t5_d_addr", l2_address, 32'h0000_B000);
        l2_resp = 1'b1;
        l2_rdata = line_of(32'h0000_B000);
        #1;
        chk_b("t5_d_resp", d_resp, 1'b1);
        cyc();
        i_read = 1'b0;
        d_read = 1'b0;
        l2_resp = 1'b0;

        // Random traffic and L2 latency; I addresses have bit 31 clear, D addresses set.
        do_reset();
        i_q.delete();
        d_q.delete();
        dw_q.delete();
        dwr_q.delete();
        i_got = 1'b0;
        d_got = 1'b0;
        busy = 1'b0;
        cnt = 0;
        cur_addr = '0;
        for (int c = 0; c < 6000; c++) begin
            cyc();
            if (i_got) begin
                i_read = 1'b0;
                i_got = 1'b0;
            end
            if (d_got) begin
                d_read = 1'b0;
                d_write = 1'b0;
                d_got = 1'b0;
            end
            if (!i_read && c < 5000 && $urandom_range(0, 3) == 0) begin
                tmp = $urandom;
                i_address = {1'b0, tmp[30:6], 6'b0};
                i_read = 1'b1;
                i_q.push_back(i_address);
            end
            if (!d_read && !d_write && c < 5000 && $urandom_range(0, 3) == 0) begin
                tmp = $urandom;
                wr = 1'($urandom_range(0, 1));
                d_address = {1'b1, tmp[30:6], 6'b0};
                d_wdata = rand_line();
                d_write = wr;
                d_read = !wr;
                d_q.push_back(d_address);
                dw_q.push_back(d_wdata);
                dwr_q.push_back(wr);
            end
            l2_resp = 1'b0;
            l2_rdata = rand_line();
            if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    l2_resp = 1'b1;
                    l2_rdata = line_of(cur_addr);
                    busy = 1'b0;
                end
            end else if (l2_read || l2_write) begin
                busy = 1'b1;
                cnt = $urandom_range(1, 20);
                cur_addr = l2_address;
                if (cur_addr[AW-1]) begin
                    chk_b("rnd_d_pending", d_q.size() != 0, 1'b1);
                    if (d_q.size() != 0) begin
                        chk_a("rnd_d_addr", l2_address, d_q[0]);
                        chk_b("rnd_d_op", l2_write, dwr_q[0]);
                        if (dwr_q[0]) chk_w("rnd_d_wdata", l2_wdata, dw_q[0]);
                    end
                end else begin
                    chk_b("rnd_i_pending", i_q.size() != 0, 1'b1);
                    if (i_q.size() != 0) begin
                        chk_a("rnd_i_addr", l2_address, i_q[0]);
                        chk_b("rnd_i_op", l2_read, 1'b1);
                    end
                end
            end
            #1;
            if (i_resp) begin
                chk_b("rnd_i_resp_expected", i_q.size() != 0, 1'b1);
                if (i_q.size() != 0) chk_w("rnd_i_rdata", i_rdata, line_of(i_q.pop_front()));
                i_got = 1'b1;
            end
            if (d_resp) begin
                chk_b("rnd_d_resp_expected", d_q.size() != 0, 1'b1);
                if (d_q.size() != 0) begin
                    chk_w("rnd_d_rdata", d_rdata, line_of(d_q.pop_front()));
                    void'(dw_q.pop_front());
                    void'(dwr_q.pop_front());
                end
                d_got = 1'b1;
            end
            if (c >= 5000 && i_q.size() == 0 && d_q.size() == 0) break;
        end
        chk_b("rnd_i_drained", i_q.size() == 0, 1'b1);
        chk_b("rnd_d_drained", d_q.size() == 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
